check_sequencer: RTL
====================

# check_sequencer

Control FSM that steps through an ordered list of check states, issuing one check request per state over a req/ack handshake, and reporting overall pass or fail. It sits directly upstream of Save_State_Unit:
- On a pause request it drives `Save_Enable` and `Prev_Check_State` into that unit.
- On resume it reloads its index from that unit's `Saved_State` output, so a paused sequence continues where it stopped.

## Interface
- `NUM_CHECKS`, default 20: number of check states, legal range 1..32; valid indices are 0..NUM_CHECKS-1.
- `CLK` in 1: single clock, all logic on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `Start` in 1: begin a sequence at index 0; sampled in IDLE, DONE or FAIL only.
- `Abort` in 1: return to IDLE from any state, with no save.
- `Pause_Req` in 1: level request to suspend the sequence.
- `Resume` in 1: pulse that leaves PAUSED.
- `Chk_Ack` in 1: one-cycle check completion, valid only while `Chk_Req`=1.
- `Chk_Pass` in 1: check result, qualified by `Chk_Ack`.
- `Saved_State` in 5: index previously saved by Save_State_Unit.
- `Chk_Req` out 1: check request, held high until acked.
- `Chk_Index` out 5: index of the check being requested.
- `Save_Enable` out 1: one-cycle save strobe to Save_State_Unit.
- `Prev_Check_State` out 5: current index; always equals `Chk_Index`.
- `Busy` out 1: high in any state except IDLE, DONE, FAIL.
- `Paused` out 1: high in PAUSED.
- `Done` out 1: high in DONE.
- `Fail` out 1: high in FAIL.
- `Fail_Index` out 5: index that failed, or the rejected restore value.

## Operation
- All outputs are registered or decoded from the state register. On `RST`, every output is 0, index = 0 and state = IDLE.
- States and transitions:
  - IDLE: on `Start`, index←0 and go to REQ.
  - REQ: `Chk_Req`=1.
    - `Chk_Ack`&`Chk_Pass` with index=NUM_CHECKS-1: go to DONE.
    - `Chk_Ack`&`Chk_Pass` otherwise: index+1 and stay in REQ.
    - `Chk_Ack`&!`Chk_Pass`: `Fail_Index`←index and go to FAIL.
    - `Pause_Req` with no ack in the same cycle: go to SAVE.
  - SAVE: `Save_Enable`=1 for exactly one cycle, with `Prev_Check_State`=index. Go to PAUSED.
  - PAUSED: `Paused`=1 and `Chk_Req`=0. On `Resume`, go to RESTORE.
  - RESTORE:
    - If `Saved_State` < NUM_CHECKS: index←`Saved_State` and go to REQ.
    - Otherwise: `Fail_Index`←`Saved_State` and go to FAIL.
  - DONE / FAIL: hold. On `Start`, index←0, clear `Fail_Index` and go to REQ.
- Priority, highest first: `RST` > `Abort` > `Chk_Ack` > `Pause_Req`.
  - If `Chk_Ack` and `Pause_Req` coincide, the ack is consumed first. The pause is taken the following cycle if `Pause_Req` is still high.
- `Abort` in any state: state←IDLE, index←0, `Save_Enable`=0. `Fail_Index` is kept.
- `Resume` outside PAUSED is ignored. `Start` while `Busy` is ignored.
- Index arithmetic is 5-bit unsigned. With NUM_CHECKS=32 the last index is 31, and the DONE check happens before any increment, so the index never wraps.
- A `Chk_Ack` while `Chk_Req`=0 is ignored.

## Timing
- Start latency: `Start` sampled at edge k gives `Chk_Req`=1, `Chk_Index`=0 from edge k+1.
- Index advance: an ack at edge k gives the new `Chk_Index` from edge k+1. `Chk_Req` stays high with no gap cycle.
- Pause latency: `Pause_Req` sampled in REQ at edge k.
  - `Chk_Req` drops and `Save_Enable` rises from edge k+1.
  - `Save_Enable` falls and `Paused` rises from edge k+2.
- Resume: `Resume` at edge k puts the state in RESTORE from k+1, and `Chk_Req` reasserts with the restored index from k+2.
  - Save_State_Unit registers on the SAVE cycle, so `Saved_State` is already valid in RESTORE.
- Maximum throughput: one check per cycle when acks arrive back-to-back.
- `RST` asserted mid-sequence clears all outputs at the next edge, including a `Save_Enable` pulse in flight.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, SAVE, PAUSED, RESTORE, DONE, FAIL), 3-bit encoding;
  - `CHECK_IDX_W`=5, which is also used by Save_State_Unit.
- Single module with no sub-module: FSM plus index register.
- Instantiated beside Save_State_Unit at the parent level, with `Save_Enable`/`Prev_Check_State` going out and `Saved_State` coming back. That unit keeps its own reset.
- Estimated 150–250 lines of RTL.

## Test plan
- NUM_CHECKS=4, `Start`, each request acked with pass after 2 cycles: indices 0,1,2,3 are issued and `Done`=1 after the 4th ack. `Fail`=0.
- Ack with `Chk_Pass`=0 at index 2: `Fail`=1, `Fail_Index`=2, `Chk_Req`=0 next cycle. `Start` then restarts at index 0 with `Fail_Index`=0.
- `Pause_Req` at index 5, then `Resume`, with Save_State_Unit connected:
  - exactly one `Save_Enable` pulse with `Prev_Check_State`=5;
  - `Paused`=1;
  - after `Resume`, `Chk_Req` reasserts within 2 cycles with `Chk_Index`=5.
- `Chk_Ack`&`Chk_Pass` in the same cycle as `Pause_Req` at index 3: index advances to 4, then `Save_Enable` fires with `Prev_Check_State`=4.
- `Saved_State` forced to 25 with NUM_CHECKS=20 during RESTORE: `Fail`=1, `Fail_Index`=25.
- `Abort` during SAVE, and `RST` during REQ: next cycle the state is IDLE, `Save_Enable`=0, and all outputs are 0. After `Abort` only, `Fail_Index` keeps its value.

Source files
------------

// File: rtl/check_sequencer_pkg.sv
// rtl/check_sequencer_pkg.sv - shared state encoding and index width for the check sequencer
package check_sequencer_pkg;

  // Index width shared with Save_State_Unit
  localparam int CHECK_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_RESTORE = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

endpackage

// File: rtl/check_sequencer.sv
// rtl/check_sequencer.sv - ordered check request sequencer with pause/save/restore
module check_sequencer
  import check_sequencer_pkg::*;
#(
  parameter int NUM_CHECKS = 20
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic                   Pause_Req,
  input  logic                   Resume,
  input  logic                   Chk_Ack,
  input  logic                   Chk_Pass,
  input  logic [CHECK_IDX_W-1:0] Saved_State,
  output logic                   Chk_Req,
  output logic [CHECK_IDX_W-1:0] Chk_Index,
  output logic                   Save_Enable,
  output logic [CHECK_IDX_W-1:0] Prev_Check_State,
  output logic                   Busy,
  output logic                   Paused,
  output logic                   Done,
  output logic                   Fail,
  output logic [CHECK_IDX_W-1:0] Fail_Index
);

  // One extra bit so NUM_CHECKS=32 is representable in the restore range check
  localparam logic [CHECK_IDX_W:0]   LP_NUM  = (CHECK_IDX_W+1)'(NUM_CHECKS);
  localparam logic [CHECK_IDX_W-1:0] LP_LAST = CHECK_IDX_W'(NUM_CHECKS - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CHECK_IDX_W-1:0] r_index;
  logic [CHECK_IDX_W-1:0] w_next_index;
  logic [CHECK_IDX_W-1:0] r_fail_index;
  logic [CHECK_IDX_W-1:0] w_next_fail_index;
  logic                   w_restore_ok;

  assign w_restore_ok = ({1'b0, Saved_State} < LP_NUM);

  // State, index and failing-index registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_index      <= '0;
      r_fail_index <= '0;
    end else begin
      r_state      <= w_next_state;
      r_index      <= w_next_index;
      r_fail_index <= w_next_fail_index;
    end
  end

  // Next-state logic; Abort overrides everything, an ack outranks a pause
  always_comb begin
    w_next_state      = r_state;
    w_next_index      = r_index;
    w_next_fail_index = r_fail_index;
    if (Abort) begin
      w_next_state = ST_IDLE;
      w_next_index = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            w_next_state = ST_REQ;
            w_next_index = '0;
          end
        end
        ST_REQ: begin
          if (Chk_Ack) begin
            if (!Chk_Pass) begin
              w_next_fail_index = r_index;
              w_next_state      = ST_FAIL;
            end else if (r_index == LP_LAST) begin
              // Last check tested before incrementing, so the index never wraps
              w_next_state = ST_DONE;
            end else begin
              w_next_index = r_index + CHECK_IDX_W'(1);
            end
          end else if (Pause_Req) begin
            w_next_state = ST_SAVE;
          end
        end
        ST_SAVE: begin
          w_next_state = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (Resume) begin
            w_next_state = ST_RESTORE;
          end
        end
        ST_RESTORE: begin
          if (w_restore_ok) begin
            w_next_index = Saved_State;
            w_next_state = ST_REQ;
          end else begin
            w_next_fail_index = Saved_State;
            w_next_state      = ST_FAIL;
          end
        end
        ST_DONE, ST_FAIL: begin
          if (Start) begin
            w_next_state      = ST_REQ;
            w_next_index      = '0;
            w_next_fail_index = '0;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_index = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the state register or driven straight from registers
  assign Chk_Req          = (r_state == ST_REQ);
  assign Chk_Index        = r_index;
  assign Save_Enable      = (r_state == ST_SAVE);
  assign Prev_Check_State = r_index;
  assign Busy             = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_FAIL);
  assign Paused           = (r_state == ST_PAUSED);
  assign Done             = (r_state == ST_DONE);
  assign Fail             = (r_state == ST_FAIL);
  assign Fail_Index       = r_fail_index;

endmodule
